// File: rtl/resp_compactor.sv
// Response compactor: folds a qualified single-bit sample stream into a CRC-style
// signature plus ones/toggle counts, and hands the result off over valid/ready.
module resp_compactor #(
   parameter int unsigned             SIG_W = 16,
   parameter logic [SIG_W-1:0]        POLY  = 16'h1021,
   parameter logic [SIG_W-1:0]        SEED  = 16'hFFFF,
   parameter int unsigned             CNT_W = 16
) (
   input  logic             iccad_clk,
   input  logic             iccad_rst,
   input  logic             start,
   input  logic [CNT_W-1:0] win_len,
   input  logic             sample_en,
   input  logic             dut_out,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] ones_cnt,
   output logic [CNT_W-1:0] toggle_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [SIG_W-1:0] sig_q,   sig_d;
   logic [CNT_W-1:0] ones_q,  ones_d;
   logic [CNT_W-1:0] tog_q,   tog_d;
   logic [CNT_W-1:0] rem_q,   rem_d;
   logic             first_q, first_d;
   logic             prev_q,  prev_d;

   logic accept;
   logic take;
   logic fb;

   assign accept = (state_q == IDLE) && start;
   assign take   = (state_q == RUN)  && sample_en;

   // State register
   always_ff @(posedge iccad_clk or posedge iccad_rst) begin
      if (iccad_rst) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = (win_len == '0) ? HOLD : RUN;
         RUN:  if (sample_en && (rem_q == CNT_W'(1))) state_d = HOLD;
         HOLD: if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy      = (state_q != IDLE);
      res_valid = (state_q == HOLD);
   end

   // Datapath next-state; result registers only move on accept or a qualified sample
   always_comb begin
      sig_d   = sig_q;
      ones_d  = ones_q;
      tog_d   = tog_q;
      rem_d   = rem_q;
      first_d = first_q;
      prev_d  = prev_q;
      fb      = sig_q[SIG_W-1] ^ dut_out;
      if (accept) begin
         sig_d   = SEED;
         ones_d  = '0;
         tog_d   = '0;
         rem_d   = win_len;
         first_d = 1'b1;
      end else if (take) begin
         sig_d  = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
         ones_d = ones_q + CNT_W'(dut_out);
         if (!first_q && (dut_out != prev_q)) tog_d = tog_q + CNT_W'(1);
         prev_d  = dut_out;
         first_d = 1'b0;
         rem_d   = rem_q - CNT_W'(1);
      end
   end

   always_ff @(posedge iccad_clk or posedge iccad_rst) begin
      if (iccad_rst) begin
         sig_q   <= '0;
         ones_q  <= '0;
         tog_q   <= '0;
         rem_q   <= '0;
         first_q <= 1'b1;
         prev_q  <= 1'b0;
      end else begin
         sig_q   <= sig_d;
         ones_q  <= ones_d;
         tog_q   <= tog_d;
         rem_q   <= rem_d;
         first_q <= first_d;
         prev_q  <= prev_d;
      end
   end

   assign signature  = sig_q;
   assign ones_cnt   = ones_q;
   assign toggle_cnt = tog_q;

endmodule

// File: tb/tb_resp_compactor.sv
// Directed self-checking bench for resp_compactor with hand-computed signatures.
module tb_resp_compactor;

   logic        iccad_clk = 1'b0;
   logic        iccad_rst;
   logic        start;
   logic [15:0] win_len;
   logic        sample_en;
   logic        dut_out;
   logic        busy;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] signature;
   logic [15:0] ones_cnt;
   logic [15:0] toggle_cnt;

   int checks = 0;
   int errors = 0;

   resp_compactor #(
      .SIG_W (16),
      .POLY  (16'h1021),
      .SEED  (16'hFFFF),
      .CNT_W (16)
   ) dut (
      .iccad_clk  (iccad_clk),
      .iccad_rst  (iccad_rst),
      .start      (start),
      .win_len    (win_len),
      .sample_en  (sample_en),
      .dut_out    (dut_out),
      .busy       (busy),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .signature  (signature),
      .ones_cnt   (ones_cnt),
      .toggle_cnt (toggle_cnt)
   );

   always #5 iccad_clk = ~iccad_clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; drive and sample 1 time unit after it
   task automatic tick();
      @(posedge iccad_clk);
      #1;
   endtask

   task automatic check_result(input string tag, input logic [15:0] sig,
                               input logic [15:0] ones, input logic [15:0] tog);
      check_val({tag, ".valid"}, 32'(res_valid), 32'd1);
      check_val({tag, ".busy"},  32'(busy),      32'd1);
      check_val({tag, ".sig"},   32'(signature), 32'(sig));
      check_val({tag, ".ones"},  32'(ones_cnt),  32'(ones));
      check_val({tag, ".tog"},   32'(toggle_cnt),32'(tog));
   endtask

   task automatic do_start(input logic [15:0] len);
      start   = 1'b1;
      win_len = len;
      tick();
      start   = 1'b0;
      check_val("start.busy", 32'(busy), 32'd1);
   endtask

   task automatic sample(input logic b);
      sample_en = 1'b1;
      dut_out   = b;
      tick();
      sample_en = 1'b0;
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_val("hs.valid", 32'(res_valid), 32'd0);
      check_val("hs.busy",  32'(busy),      32'd0);
   endtask

   initial begin
      iccad_rst = 1'b1;
      start     = 1'b0;
      win_len   = '0;
      sample_en = 1'b0;
      dut_out   = 1'b0;
      res_ready = 1'b0;
      #12;
      check_val("rst.busy",  32'(busy),       32'd0);
      check_val("rst.valid", 32'(res_valid),  32'd0);
      check_val("rst.sig",   32'(signature),  32'd0);
      check_val("rst.ones",  32'(ones_cnt),   32'd0);
      check_val("rst.tog",   32'(toggle_cnt), 32'd0);
      iccad_rst = 1'b0;
      tick();

      // Two-sample window 1,0, then backpressure with ignored starts
      do_start(16'd2);
      check_val("two.valid0", 32'(res_valid), 32'd0);
      sample(1'b1);
      check_val("two.valid1", 32'(res_valid), 32'd0);
      sample(1'b0);
      check_result("two", 16'hEFDD, 16'd1, 16'd1);
      for (int i = 0; i < 5; i++) begin
         start     = 1'b1;
         win_len   = 16'd3;
         sample_en = 1'b1;
         dut_out   = i[0];
         tick();
         check_result("bp", 16'hEFDD, 16'd1, 16'd1);
      end
      sample_en = 1'b0;
      start     = 1'b1;
      handshake();
      start = 1'b0;
      check_val("idle.sig", 32'(signature), 32'hEFDD);
      tick();
      check_val("hs_start.busy", 32'(busy), 32'd0);

      // Constant ones
      do_start(16'd4);
      for (int i = 0; i < 4; i++) sample(1'b1);
      check_result("ones", 16'hFFF0, 16'd4, 16'd0);
      handshake();

      // Empty window
      do_start(16'd0);
      check_result("empty", 16'hFFFF, 16'd0, 16'd0);
      tick();
      check_result("empty.hold", 16'hFFFF, 16'd0, 16'd0);
      handshake();

      // Gapped sampling, with res_ready high during RUN having no effect
      do_start(16'd2);
      res_ready = 1'b1;
      sample(1'b1);
      for (int i = 0; i < 3; i++) begin
         dut_out = ~dut_out;
         tick();
         check_val("gap.valid", 32'(res_valid), 32'd0);
      end
      res_ready = 1'b0;
      sample(1'b0);
      check_result("gap", 16'hEFDD, 16'd1, 16'd1);
      handshake();

      // Three samples 1,0,1
      do_start(16'd3);
      sample(1'b1);
      sample(1'b0);
      sample(1'b1);
      check_result("alt", 16'hDFBA, 16'd2, 16'd2);
      handshake();

      // Reset mid-window
      do_start(16'd8);
      for (int i = 0; i < 3; i++) sample(1'b1);
      check_val("mid.busy", 32'(busy), 32'd1);
      #2;
      iccad_rst = 1'b1;
      #1;
      check_val("mrst.busy",  32'(busy),       32'd0);
      check_val("mrst.valid", 32'(res_valid),  32'd0);
      check_val("mrst.sig",   32'(signature),  32'd0);
      check_val("mrst.ones",  32'(ones_cnt),   32'd0);
      check_val("mrst.tog",   32'(toggle_cnt), 32'd0);
      tick();
      iccad_rst = 1'b0;
      tick();
      do_start(16'd1);
      sample(1'b0);
      check_result("post", 16'hEFDF, 16'd0, 16'd0);
      handshake();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
